edge_event_arbiter: RTL and testbench

- Watches NUM_REQ single-bit level signals (enables/valids) and turns each rising edge into a pending event.
- Round-robin arbitrates the pending events onto one shared capture port.
- At grant, latches the shared DATA_W-bit data bus and presents it with the winner's index on a valid/ready output.
- Sits between free-running enable logic and a single consumer (checker, monitor FIFO) that accepts one event per cycle.

---
 rtl/edge_event_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture with round-robin arbitration onto a single valid/ready capture port.
// Optional macro EDGE_EVENT_ARBITER_NEGEDGE_EN adds falling-edge events interleaved as rise0, fall0, rise1, ...
module edge_event_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int ID_W    = 2,
    parameter int DROP_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_level,
    input  logic [DATA_W-1:0]  data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic               out_fall,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_REQ-1:0] pending,
    output logic [DROP_W-1:0]  drop_cnt
);

`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
    localparam int NSLOT = 2 * NUM_REQ;
`else
    localparam int NSLOT = NUM_REQ;
`endif
    localparam int PTR_W = $clog2(NSLOT);
    localparam int CNT_W = $clog2(NSLOT + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t          state_r;
    logic                out_valid_r;
    logic [ID_W-1:0]     out_id_r;
    logic                out_fall_r;
    logic [DATA_W-1:0]   out_data_r;

    logic [NUM_REQ-1:0]  prev_q_r;
    logic [NUM_REQ-1:0]  pend_rise_r;
    logic [NUM_REQ-1:0]  rise_s;
    logic [NUM_REQ-1:0]  grant_rise_s;
    logic [NUM_REQ-1:0]  drop_rise_s;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
    logic [NUM_REQ-1:0]  pend_fall_r;
    logic [NUM_REQ-1:0]  fall_s;
    logic [NUM_REQ-1:0]  grant_fall_s;
    logic [NUM_REQ-1:0]  drop_fall_s;
`endif

    logic [NSLOT-1:0]    slots_s;
    logic                found_s;
    logic                slot_free_s;
    logic                grant_s;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    win_slot_s;
    logic [PTR_W-1:0]    rr_next_s;
    logic [ID_W-1:0]     win_id_s;
    logic                win_fall_s;
    logic [CNT_W-1:0]    drop_num_s;
    logic [SUM_W-1:0]    drop_sum_s;
    logic [DROP_W-1:0]   drop_cnt_r;
    logic [DROP_W-1:0]   drop_next_s;

    assign rise_s      = req_level & ~prev_q_r;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
    assign fall_s      = ~req_level & prev_q_r;
`endif
    assign slot_free_s = (state_r == ST_EMPTY) || out_ready;
    assign grant_s     = slot_free_s && found_s;

    // Flatten the pending vectors into arbitration slot order.
    always_comb begin
        slots_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
            slots_s[2*i]   = pend_rise_r[i];
            slots_s[2*i+1] = pend_fall_r[i];
`else
            slots_s[i]     = pend_rise_r[i];
`endif
        end
    end

    // Round-robin search: first set slot at or above rr_ptr, wrapping.
    always_comb begin : arb_search
        int unsigned idx_v;
        logic [PTR_W-1:0] cand_v;
        logic hit_v;
        idx_v      = 0;
        cand_v     = '0;
        hit_v      = 1'b0;
        found_s    = 1'b0;
        win_slot_s = '0;
        for (int o = 0; o < NSLOT; o++) begin
            idx_v      = (int'(rr_ptr_r) + o) % NSLOT;
            cand_v     = PTR_W'(idx_v);
            hit_v      = ~found_s & slots_s[cand_v];
            win_slot_s = hit_v ? cand_v : win_slot_s;
            found_s    = found_s | hit_v;
        end
    end

    // Decode winner slot into requester index, polarity and next pointer.
    always_comb begin
        rr_next_s = (win_slot_s == PTR_W'(NSLOT - 1)) ? '0 : (win_slot_s + 1'b1);
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
        win_id_s   = ID_W'(win_slot_s >> 1);
        win_fall_s = win_slot_s[0];
`else
        win_id_s   = ID_W'(win_slot_s);
        win_fall_s = 1'b0;
`endif
    end

    // One-hot clear masks for the granted slot.
    always_comb begin
        grant_rise_s = '0;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
        grant_fall_s = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
            grant_rise_s[i] = grant_s && (win_slot_s == PTR_W'(2 * i));
            grant_fall_s[i] = grant_s && (win_slot_s == PTR_W'(2 * i + 1));
`else
            grant_rise_s[i] = grant_s && (win_slot_s == PTR_W'(i));
`endif
        end
    end

    // An edge is lost only when its slot is still pending and not being drained this cycle.
    assign drop_rise_s = rise_s & pend_rise_r & ~grant_rise_s;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
    assign drop_fall_s = fall_s & pend_fall_r & ~grant_fall_s;
`endif

    // Population count of lost edges and saturating accumulation.
    always_comb begin
        drop_num_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop_num_s = drop_num_s + CNT_W'(drop_rise_s[i]);
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
            drop_num_s = drop_num_s + CNT_W'(drop_fall_s[i]);
`endif
        end
        drop_sum_s = SUM_W'(drop_cnt_r) + SUM_W'(drop_num_s);
        if (drop_sum_s > SUM_W'({DROP_W{1'b1}})) begin
            drop_next_s = {DROP_W{1'b1}};
        end else begin
            drop_next_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // Edge history, pending vectors, drop counter and arbitration pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q_r    <= '0;
            pend_rise_r <= '0;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
            pend_fall_r <= '0;
`endif
            drop_cnt_r  <= '0;
            rr_ptr_r    <= '0;
        end else begin
            prev_q_r    <= req_level;
            pend_rise_r <= (pend_rise_r & ~grant_rise_s) | rise_s;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
            pend_fall_r <= (pend_fall_r & ~grant_fall_s) | fall_s;
`endif
            drop_cnt_r  <= drop_next_s;
            if (grant_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Output slot FSM: a grant always reloads the slot; a lone transfer empties it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_id_r    <= '0;
            out_fall_r  <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (grant_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        out_id_r    <= win_id_s;
                        out_fall_r  <= win_fall_s;
                        out_data_r  <= data_in;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (grant_s) begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        out_id_r    <= win_id_s;
                        out_fall_r  <= win_fall_s;
                        out_data_r  <= data_in;
                    end else if (out_ready) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_fall  = out_fall_r;
    assign out_data  = out_data_r;
    assign pending   = pend_rise_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: stimulus pushes expected events, a negedge monitor pops them.
module tb_edge_event_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 256;
    localparam int ID_W    = 2;
    localparam int DROP_W  = 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              fall;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic               clock;
    logic               reset;
    logic [NUM_REQ-1:0] req_level;
    logic [DATA_W-1:0]  data_in;
    logic               out_valid;
    logic               out_ready;
    logic [ID_W-1:0]    out_id;
    logic               out_fall;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_REQ-1:0] pending;
    logic [DROP_W-1:0]  drop_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    edge_event_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .DROP_W(DROP_W)
    ) dut (
        .clock(clock), .reset(reset), .req_level(req_level), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_fall(out_fall), .out_data(out_data), .pending(pending), .drop_cnt(drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic fall, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id   = ID_W'(id);
        e.fall = fall;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req_level = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got id=%0d fall=%0b, expected no event", out_id, out_fall);
            end else begin
                e = exp_q.pop_front();
                if (out_id !== e.id || out_fall !== e.fall || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL event: got id=%0d fall=%0b data=%0h, expected id=%0d fall=%0b data=%0h",
                             out_id, out_fall, out_data, e.id, e.fall, e.data);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_level = 4'b0000;
        data_in   = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("reset_valid",   256'(out_valid), 256'd0);
        chk("reset_pending", 256'(pending),   256'd0);
        chk("reset_drop",    256'(drop_cnt),  256'd0);
        chk("reset_id",      256'(out_id),    256'd0);
        chk("reset_data",    out_data,        256'd0);
        reset = 1'b0;

`ifndef EDGE_EVENT_ARBITER_NEGEDGE_EN
        // Single edge: pending one cycle, event the next.
        req_level = 4'b0001;
        data_in   = 256'hA5;
        push(0, 1'b0, 256'hA5);
        step();
        chk("single_pending_set", 256'(pending),   256'h1);
        chk("single_not_valid",   256'(out_valid), 256'd0);
        step();
        chk("single_valid",       256'(out_valid), 256'd1);
        chk("single_pending_clr", 256'(pending),   256'd0);
        req_level = 4'b0000;
        step();
        chk("single_drained",     256'(out_valid), 256'd0);

        // Round-robin over all four, then 0 and 3 after wrap.
        do_reset();
        data_in   = 256'h1111;
        req_level = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 1'b0, 256'h1111);
        step();
        chk("rr_pending_all", 256'(pending), 256'hF);
        req_level = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        chk("rr_pending_empty", 256'(pending), 256'd0);
        data_in   = 256'h2222;
        req_level = 4'b1001;
        push(0, 1'b0, 256'h2222);
        push(3, 1'b0, 256'h2222);
        step();
        chk("rr_pending_09", 256'(pending), 256'h9);
        step();
        step();
        req_level = 4'b0000;
        step();
        step();

        // Stall and drop on requester 1.
        do_reset();
        out_ready = 1'b0;
        data_in   = 256'hBEEF;
        req_level = 4'b0010;
        push(1, 1'b0, 256'hBEEF);
        step();
        req_level = 4'b0000;
        step();
        data_in   = 256'hDEAD;
        req_level = 4'b0010;
        step();
        chk("stall_pending", 256'(pending),  256'h2);
        chk("stall_data",    out_data,       256'hBEEF);
        chk("stall_drop0",   256'(drop_cnt), 256'd0);
        for (int k = 0; k < 2; k++) begin
            req_level = 4'b0000;
            step();
            req_level = 4'b0010;
            step();
        end
        chk("stall_drop2",  256'(drop_cnt), 256'd2);
        chk("stall_id",     256'(out_id),   256'd1);
        chk("stall_hold",   out_data,       256'hBEEF);
        out_ready = 1'b1;
        push(1, 1'b0, 256'hDEAD);
        step();
        req_level = 4'b0000;
        step();
        chk("stall_drained", 256'(out_valid), 256'd0);

        // Drop counter saturation.
        do_reset();
        out_ready = 1'b0;
        data_in   = 256'hC0FFEE;
        push(0, 1'b0, 256'hC0FFEE);
        req_level = 4'b1111;
        step();
        req_level = 4'b0000;
        step();
        req_level = 4'b1111;
        step();
        chk("sat_drop3", 256'(drop_cnt), 256'd3);
        for (int k = 0; k < 150; k++) begin
            req_level = 4'b0000;
            step();
            req_level = 4'b1111;
            step();
        end
        chk("sat_drop_ff", 256'(drop_cnt), 256'hFF);
        req_level = 4'b0000;
        out_ready = 1'b1;
        push(1, 1'b0, 256'hC0FFEE);
        push(2, 1'b0, 256'hC0FFEE);
        push(3, 1'b0, 256'hC0FFEE);
        push(0, 1'b0, 256'hC0FFEE);
        for (int k = 0; k < 5; k++) step();
        chk("sat_hold_ff", 256'(drop_cnt), 256'hFF);

        // Reset mid-operation discards held event and pending.
        do_reset();
        out_ready = 1'b0;
        data_in   = 256'h5555;
        req_level = 4'b0001;
        step();
        step();
        req_level = 4'b1010;
        step();
        chk("mid_valid",   256'(out_valid), 256'd1);
        chk("mid_pending", 256'(pending),   256'hA);
        reset     = 1'b1;
        req_level = 4'b0100;
        step();
        reset     = 1'b0;
        chk("mid_rst_valid",   256'(out_valid), 256'd0);
        chk("mid_rst_pending", 256'(pending),   256'd0);
        chk("mid_rst_id",      256'(out_id),    256'd0);
        chk("mid_rst_data",    out_data,        256'd0);
        chk("mid_rst_drop",    256'(drop_cnt),  256'd0);
        out_ready = 1'b1;
        push(2, 1'b0, 256'h5555);
        step();
        chk("mid_pending_04", 256'(pending),   256'h4);
        chk("mid_not_valid",  256'(out_valid), 256'd0);
        step();
        chk("mid_id2", 256'(out_id), 256'd2);
        req_level = 4'b0000;
        step();
`endif

        // Falling edge on requester 2.
        do_reset();
        out_ready = 1'b1;
        data_in   = 256'h77;
        req_level = 4'b0100;
        push(2, 1'b0, 256'h77);
        step();
        step();
        chk("fall_rise_valid", 256'(out_valid), 256'd1);
        req_level = 4'b0000;
`ifdef EDGE_EVENT_ARBITER_NEGEDGE_EN
        push(2, 1'b1, 256'h77);
        step();
        step();
        chk("fall_event_valid", 256'(out_valid), 256'd1);
        chk("fall_event_flag",  256'(out_fall),  256'd1);
        step();
        step();
`else
        step();
        step();
        chk("fall_ignored_valid",   256'(out_valid), 256'd0);
        chk("fall_ignored_pending", 256'(pending),   256'd0);
        chk("fall_tied_zero",       256'(out_fall),  256'd0);
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
